den_gt_ctrl: RTL and testbench



---
 rtl/den_gt_ctrl.sv | 171 +++++++++++++++++
 tb/tb_den_gt_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/den_gt_ctrl.sv
// den_gt_ctrl: free-running two-way traffic-light controller (approaches A/B).
// Moore FSM with per-phase cycle counter and registered lamp drive.
// Optional all-red clearance phases are built with macro DEN_GT_ALL_RED_EN.
module den_gt_ctrl #(
  parameter int unsigned T_GREEN  = 8,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  output logic [5:0] light
);

  // Zero durations behave as one cycle
  localparam int unsigned C_GREEN  = (T_GREEN  == 0) ? 1 : T_GREEN;
  localparam int unsigned C_YELLOW = (T_YELLOW == 0) ? 1 : T_YELLOW;
  localparam int unsigned C_ALLRED = (T_ALLRED == 0) ? 1 : T_ALLRED;
  localparam int unsigned C_MAX_GY = (C_GREEN > C_YELLOW) ? C_GREEN : C_YELLOW;
  localparam int unsigned C_MAX    = (C_MAX_GY > C_ALLRED) ? C_MAX_GY : C_ALLRED;

  localparam logic [CNT_W-1:0] C_G_LAST  = CNT_W'(C_GREEN - 1);
  localparam logic [CNT_W-1:0] C_Y_LAST  = CNT_W'(C_YELLOW - 1);
`ifdef DEN_GT_ALL_RED_EN
  localparam logic [CNT_W-1:0] C_AR_LAST = CNT_W'(C_ALLRED - 1);
`endif

  // Lamp patterns {A red, A yel, A grn, B red, B yel, B grn}
  localparam logic [5:0] L_ALL_RED = 6'b100100;
  localparam logic [5:0] L_A_GRN   = 6'b001100;
  localparam logic [5:0] L_A_YEL   = 6'b010100;
  localparam logic [5:0] L_B_GRN   = 6'b100001;
  localparam logic [5:0] L_B_YEL   = 6'b100010;

  // Counter must be able to reach the longest phase's terminal count
  if (((C_MAX - 1) >> CNT_W) != 0) begin : g_cnt_w_chk
    $error("den_gt_ctrl: CNT_W too narrow for the longest phase");
  end

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_A_GRN = 3'd1,
    S_A_YEL = 3'd2,
    S_B_GRN = 3'd3,
    S_B_YEL = 3'd4,
    S_AR1   = 3'd5,
    S_AR2   = 3'd6
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_light;
  logic [CNT_W-1:0] w_last;
  logic             w_done;

  // Lamp pattern for a given state; unknown encodings show all-red
  function automatic logic [5:0] f_decode(input state_t s);
    case (s)
      S_A_GRN: f_decode = L_A_GRN;
      S_A_YEL: f_decode = L_A_YEL;
      S_B_GRN: f_decode = L_B_GRN;
      S_B_YEL: f_decode = L_B_YEL;
      default: f_decode = L_ALL_RED;
    endcase
  endfunction

  // Terminal count of the current phase
  always_comb begin
    w_last = '0;
    case (r_state)
      S_A_GRN, S_B_GRN: w_last = C_G_LAST;
      S_A_YEL, S_B_YEL: w_last = C_Y_LAST;
`ifdef DEN_GT_ALL_RED_EN
      S_AR1, S_AR2:     w_last = C_AR_LAST;
`endif
      default:          w_last = '0;
    endcase
    w_done = (r_cnt == w_last);
  end

  // Phase sequencer; lamp register is loaded with the decode of the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_light <= L_ALL_RED;
    end else begin
      case (r_state)
        S_INIT: begin
          r_state <= S_A_GRN;
          r_cnt   <= '0;
          r_light <= f_decode(S_A_GRN);
        end
        S_A_GRN: begin
          if (w_done) begin
            r_state <= S_A_YEL;
            r_cnt   <= '0;
            r_light <= f_decode(S_A_YEL);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_A_YEL: begin
          if (w_done) begin
`ifdef DEN_GT_ALL_RED_EN
            r_state <= S_AR1;
            r_light <= f_decode(S_AR1);
`else
            r_state <= S_B_GRN;
            r_light <= f_decode(S_B_GRN);
`endif
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_B_GRN: begin
          if (w_done) begin
            r_state <= S_B_YEL;
            r_cnt   <= '0;
            r_light <= f_decode(S_B_YEL);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_B_YEL: begin
          if (w_done) begin
`ifdef DEN_GT_ALL_RED_EN
            r_state <= S_AR2;
            r_light <= f_decode(S_AR2);
`else
            r_state <= S_A_GRN;
            r_light <= f_decode(S_A_GRN);
`endif
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`ifdef DEN_GT_ALL_RED_EN
        S_AR1: begin
          if (w_done) begin
            r_state <= S_B_GRN;
            r_cnt   <= '0;
            r_light <= f_decode(S_B_GRN);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_AR2: begin
          if (w_done) begin
            r_state <= S_A_GRN;
            r_cnt   <= '0;
            r_light <= f_decode(S_A_GRN);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif
        default: begin
          r_state <= S_INIT;
          r_cnt   <= '0;
          r_light <= L_ALL_RED;
        end
      endcase
    end
  end

  assign light = r_light;

endmodule

// File: tb/tb_den_gt_ctrl.sv
// tb_den_gt_ctrl: self-checking bench for den_gt_ctrl (default and minimum durations).
module tb_den_gt_ctrl;

  localparam int unsigned TG   = 8;
  localparam int unsigned TY   = 3;
  localparam int unsigned TA   = 1;
  localparam int unsigned TG_M = 2;
  localparam int unsigned TY_M = 1;
`ifdef DEN_GT_ALL_RED_EN
  localparam int unsigned AR_USED = 1;
`else
  localparam int unsigned AR_USED = 0;
`endif

  logic       clk;
  logic       reset;
  logic       reset_m;
  logic [5:0] light;
  logic [5:0] light_m;

  int n_tests;
  int n_fail;
  logic [5:0] exp_q[$];

  den_gt_ctrl #(.T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .CNT_W(8)) u_dut (
    .clk  (clk),
    .reset(reset),
    .light(light)
  );

  den_gt_ctrl #(.T_GREEN(TG_M), .T_YELLOW(TY_M), .T_ALLRED(TA), .CNT_W(8)) u_dut_min (
    .clk  (clk),
    .reset(reset_m),
    .light(light_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference lamp pattern k edges after reset release (k >= 1)
  function automatic logic [5:0] f_model(input int k, input int g, input int y, input int a);
    int p;
    int pos;
    p   = 2 * (g + y + a);
    pos = (k - 1) % p;
    if (pos < g)                    return 6'b001100;
    else if (pos < g + y)           return 6'b010100;
    else if (pos < g + y + a)       return 6'b100100;
    else if (pos < 2 * g + y + a)   return 6'b100001;
    else if (pos < 2 * g + 2*y + a) return 6'b100010;
    else                            return 6'b100100;
  endfunction

  task automatic test_reset();
    reset   = 1'b0;
    reset_m = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_tests++;
      if (light !== 6'b100100) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=100100", i, light);
      end
      n_tests++;
      if (light_m !== 6'b100100) begin
        n_fail++;
        $display("FAIL reset_hold_min cyc=%0d got=%b exp=100100", i, light_m);
      end
    end
  endtask

  // Release at a negedge, then score `edges` cycles through the queue
  task automatic run_scored(input string name, input int edges);
    reset = 1'b1;
    for (int k = 1; k <= edges; k++) begin
      @(posedge clk);
      exp_q.push_back(f_model(k, TG, TY, TA * AR_USED));
      @(negedge clk);
      begin
        logic [5:0] e;
        e = exp_q.pop_front();
        n_tests++;
        if (light !== e) begin
          n_fail++;
          $display("FAIL %s edge=%0d got=%b exp=%b", name, k, light, e);
        end
      end
    end
  endtask

  task automatic test_sequence();
    run_scored("sequence", 35);
  endtask

  task automatic test_midphase_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_scored("pre_reset", 14);
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (light !== 6'b100100) begin
      n_fail++;
      $display("FAIL async_reset got=%b exp=100100", light);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (light !== 6'b100100) begin
      n_fail++;
      $display("FAIL async_reset_hold got=%b exp=100100", light);
    end
    run_scored("restart", 12);
  endtask

  task automatic test_invariants();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_tests++;
      if (!($onehot(light[5:3]) && $onehot(light[2:0]) && (light[5] || light[2]))) begin
        n_fail++;
        $display("FAIL invariant cyc=%0d got=%b exp=one-hot per approach, one red", i, light);
      end
    end
  endtask

  task automatic test_min_durations();
    reset_m = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      exp_q.push_back(f_model(k, TG_M, TY_M, TA * AR_USED));
      @(negedge clk);
      begin
        logic [5:0] e;
        e = exp_q.pop_front();
        n_tests++;
        if (light_m !== e) begin
          n_fail++;
          $display("FAIL min_durations edge=%0d got=%b exp=%b", k, light_m, e);
        end
      end
    end
  endtask

  task automatic test_queue_drained();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drained got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    reset_m = 1'b0;
    test_reset();
    test_sequence();
    test_midphase_reset();
    test_invariants();
    test_min_durations();
    test_queue_drained();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
